// File: rtl/lcd_rd_timing_pkg.sv
// Shared timing defaults, RGB565 colours and helpers for the LCD read-timing block.
// The colour-bar helpers are only used when LCD_TEST_PATTERN_EN is defined.
package lcd_timing_pkg;

  localparam int DEF_H_SYNC  = 41;
  localparam int DEF_H_BACK  = 2;
  localparam int DEF_H_DISP  = 480;
  localparam int DEF_H_FRONT = 2;
  localparam int DEF_V_SYNC  = 10;
  localparam int DEF_V_BACK  = 2;
  localparam int DEF_V_DISP  = 272;
  localparam int DEF_V_FRONT = 2;
  localparam int DEF_CNT_W   = 12;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  typedef enum logic [2:0] {
    BAR_WHITE,
    BAR_YELLOW,
    BAR_CYAN,
    BAR_GREEN,
    BAR_MAGENTA,
    BAR_RED,
    BAR_BLUE,
    BAR_BLACK
  } bar_e;

  function automatic int frame_total(input int sync_w, input int back_w,
                                     input int disp_w, input int front_w);
    return sync_w + back_w + disp_w + front_w;
  endfunction

  function automatic logic [15:0] bar_rgb(input bar_e bar);
    logic [15:0] rgb;
    rgb = RGB_BLACK;
    case (bar)
      BAR_WHITE:   rgb = RGB_WHITE;
      BAR_YELLOW:  rgb = RGB_YELLOW;
      BAR_CYAN:    rgb = RGB_CYAN;
      BAR_GREEN:   rgb = RGB_GREEN;
      BAR_MAGENTA: rgb = RGB_MAGENTA;
      BAR_RED:     rgb = RGB_RED;
      BAR_BLUE:    rgb = RGB_BLUE;
      default:     rgb = RGB_BLACK;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/lcd_rd_timing_if.sv
// Bundle of the SDRAM read-port and LCD panel signals around lcd_rd_timing.
// pattern_sel exists only when LCD_TEST_PATTERN_EN is defined.
interface lcd_rd_timing_if #(
  parameter int CNT_W = lcd_timing_pkg::DEF_CNT_W
);

  logic             sdram_init_done;
  logic [15:0]      rd_data;
  logic             rd_en;
  logic             rd_load;
  logic             sdram_read_valid;
  logic [12:0]      rd_h_pixel;
  logic             lcd_hs;
  logic             lcd_vs;
  logic             lcd_de;
  logic [15:0]      lcd_rgb;
  logic [CNT_W-1:0] pixel_xpos;
  logic [CNT_W-1:0] pixel_ypos;
`ifdef LCD_TEST_PATTERN_EN
  logic             pattern_sel;
`endif

`ifdef LCD_TEST_PATTERN_EN
  modport master (
    input  sdram_init_done, rd_data, pattern_sel,
    output rd_en, rd_load, sdram_read_valid, rd_h_pixel,
           lcd_hs, lcd_vs, lcd_de, lcd_rgb, pixel_xpos, pixel_ypos
  );

  modport slave (
    output sdram_init_done, rd_data, pattern_sel,
    input  rd_en, rd_load, sdram_read_valid, rd_h_pixel,
           lcd_hs, lcd_vs, lcd_de, lcd_rgb, pixel_xpos, pixel_ypos
  );
`else
  modport master (
    input  sdram_init_done, rd_data,
    output rd_en, rd_load, sdram_read_valid, rd_h_pixel,
           lcd_hs, lcd_vs, lcd_de, lcd_rgb, pixel_xpos, pixel_ypos
  );

  modport slave (
    output sdram_init_done, rd_data,
    input  rd_en, rd_load, sdram_read_valid, rd_h_pixel,
           lcd_hs, lcd_vs, lcd_de, lcd_rgb, pixel_xpos, pixel_ypos
  );
`endif

endinterface

// File: rtl/lcd_rd_timing_sync_cnt.sv
// Horizontal/vertical raster counters; both are parked at zero while init_ok is low
// so every frame after (re)initialisation starts from the top-left corner.
module lcd_sync_cnt
  import lcd_timing_pkg::*;
#(
  parameter int H_TOT = frame_total(DEF_H_SYNC, DEF_H_BACK, DEF_H_DISP, DEF_H_FRONT),
  parameter int V_TOT = frame_total(DEF_V_SYNC, DEF_V_BACK, DEF_V_DISP, DEF_V_FRONT),
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_ok,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!init_ok) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + ONE;
    end else begin
      h_cnt <= h_cnt + ONE;
    end
  end

endmodule

// File: rtl/lcd_rd_timing.sv
// LCD timing generator fed straight from the SDRAM read FIFO (same clock as rd_clk).
// Define LCD_TEST_PATTERN_EN to add pattern_sel and the built-in 8-bar colour pattern.
module lcd_rd_timing
  import lcd_timing_pkg::*;
#(
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BACK  = DEF_H_BACK,
  parameter int H_DISP  = DEF_H_DISP,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BACK  = DEF_V_BACK,
  parameter int V_DISP  = DEF_V_DISP,
  parameter int V_FRONT = DEF_V_FRONT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic            clk,
  input logic            rst_n,
  lcd_rd_timing_if.master lcd
);

  localparam int H_TOT = frame_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
  localparam int V_TOT = frame_total(V_SYNC, V_BACK, V_DISP, V_FRONT);

  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HA     = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] VA     = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] HA_END = CNT_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CNT_W-1:0] VA_END = CNT_W'(V_SYNC + V_BACK + V_DISP);

  logic             init_meta;
  logic             init_ok;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             act_h;
  logic             act_v;
  logic             win;
  logic             hs_q;
  logic             vs_q;
  logic             de_q;
  logic             load_q;
  logic             valid_q;
  logic [CNT_W-1:0] x_q;
  logic [CNT_W-1:0] y_q;
  logic [15:0]      rgb;

  // sdram_init_done comes from the SDRAM reference clock, so it is brought across with two flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_meta <= 1'b0;
      init_ok   <= 1'b0;
    end else begin
      init_meta <= lcd.sdram_init_done;
      init_ok   <= init_meta;
    end
  end

  lcd_sync_cnt #(
    .H_TOT (H_TOT),
    .V_TOT (V_TOT),
    .CNT_W (CNT_W)
  ) u_sync_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .init_ok (init_ok),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt)
  );

  assign act_h = (h_cnt >= HA) && (h_cnt < HA_END);
  assign act_v = (v_cnt >= VA) && (v_cnt < VA_END);
  assign win   = init_ok & act_h & act_v;

`ifdef LCD_TEST_PATTERN_EN
  assign lcd.rd_en = win & ~lcd.pattern_sel;
`else
  assign lcd.rd_en = win;
`endif

  // Panel outputs lag the counters by one clock so the FIFO word requested by rd_en
  // lines up with lcd_de; syncs are gated by init_ok so an idle panel sees them high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      de_q    <= 1'b0;
      load_q  <= 1'b0;
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      hs_q    <= ~(init_ok & (h_cnt < HS_END));
      vs_q    <= ~(init_ok & (v_cnt < VS_END));
      de_q    <= win;
      load_q  <= init_ok & (v_cnt < VS_END);
      valid_q <= init_ok;
      if (win) begin
        x_q <= h_cnt - HA;
        y_q <= v_cnt - VA;
      end else begin
        x_q <= '0;
      end
    end
  end

`ifdef LCD_TEST_PATTERN_EN
  logic [2:0] bar_idx;
  assign bar_idx = 3'((32'(x_q) * 32'd8) / 32'(H_DISP));
`endif

  always_comb begin
    rgb = 16'h0000;
    if (de_q) begin
`ifdef LCD_TEST_PATTERN_EN
      rgb = lcd.pattern_sel ? bar_rgb(bar_e'(bar_idx)) : lcd.rd_data;
`else
      rgb = lcd.rd_data;
`endif
    end
  end

  assign lcd.lcd_hs           = hs_q;
  assign lcd.lcd_vs           = vs_q;
  assign lcd.lcd_de           = de_q;
  assign lcd.lcd_rgb          = rgb;
  assign lcd.pixel_xpos       = x_q;
  assign lcd.pixel_ypos       = y_q;
  assign lcd.rd_load          = load_q;
  assign lcd.sdram_read_valid = valid_q;
  assign lcd.rd_h_pixel       = 13'(H_DISP);

endmodule

// File: tb/tb_lcd_rd_timing.sv
// Self-checking bench for lcd_rd_timing on a small 15x8 raster.
// Build with LCD_TEST_PATTERN_EN defined to also exercise the colour-bar pattern.
module tb_lcd_rd_timing;

  localparam int H_SYNC  = 2;
  localparam int H_BACK  = 3;
  localparam int H_DISP  = 8;
  localparam int H_FRONT = 2;
  localparam int V_SYNC  = 1;
  localparam int V_BACK  = 2;
  localparam int V_DISP  = 4;
  localparam int V_FRONT = 1;
  localparam int CNT_W   = 12;
  localparam int H_TOT   = 15;
  localparam int V_TOT   = 8;
  localparam int HA      = 5;
  localparam int VA      = 3;
  localparam int NVEC    = 17;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  lcd_rd_timing_if #(.CNT_W(CNT_W)) lcd_bus ();

  lcd_rd_timing #(
    .H_SYNC  (H_SYNC),
    .H_BACK  (H_BACK),
    .H_DISP  (H_DISP),
    .H_FRONT (H_FRONT),
    .V_SYNC  (V_SYNC),
    .V_BACK  (V_BACK),
    .V_DISP  (V_DISP),
    .V_FRONT (V_FRONT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lcd   (lcd_bus)
  );

  // n = clock edges since reset release (or init re-assert), sampled 1 time unit after the edge
  typedef struct {
    int   n;
    logic rd_en;
    logic de;
    logic hs;
    logic vs;
    logic load;
    logic srv;
    int   x;
    int   y;
  } vec_t;

  vec_t vecs [NVEC];

`ifdef LCD_TEST_PATTERN_EN
  logic [15:0] bar_colors [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                  16'hF81F, 16'hF800, 16'h001F, 16'h0000};
`endif

  function automatic int h_of(input int k);
    return k % H_TOT;
  endfunction

  function automatic int v_of(input int k);
    return (k / H_TOT) % V_TOT;
  endfunction

  function automatic bit in_window(input int k);
    return (v_of(k) >= VA) && (v_of(k) <= VA + V_DISP - 1) &&
           (h_of(k) >= HA) && (h_of(k) <= HA + H_DISP - 1);
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic init_done);
    lcd_bus.sdram_init_done = init_done;
  endtask

  // Runs n_max cycles after init becomes visible, emulating the FIFO (data one clock after rd_en)
  // and comparing against a raster model; optionally also against the hand-written vectors
  task automatic run_frames(input int n_max, input bit use_table, input int y_init);
    int          drive_cnt = 0;
    int          model_cnt = 0;
    bit          prev_rd   = 1'b0;
    int          exp_x;
    int          exp_y     = y_init;
    bit          exp_rd;
    bit          exp_de;
    logic [15:0] exp_rgb;
    int          rd_cnt = 0;
    int          de_cnt = 0;
    int          hs_lo  = 0;
    int          vs_lo  = 0;
    int          ld_cnt = 0;
    lcd_bus.rd_data = 16'h0000;
    for (int n = 1; n <= n_max; n++) begin
      @(posedge clk);
      if (prev_rd) begin
        lcd_bus.rd_data = 16'(32'h1000 + drive_cnt);
        drive_cnt++;
      end
      #1;
      prev_rd = lcd_bus.rd_en;
      exp_rd  = (n >= 2) && in_window(n - 2);
      exp_de  = (n >= 3) && in_window(n - 3);
      exp_x   = 0;
      exp_rgb = 16'h0000;
      if (exp_de) begin
        exp_x   = h_of(n - 3) - HA;
        exp_y   = v_of(n - 3) - VA;
        exp_rgb = 16'(32'h1000 + model_cnt);
        model_cnt++;
      end
      check_output($sformatf("rd_en@%0d", n), 32'(lcd_bus.rd_en), 32'(exp_rd));
      check_output($sformatf("lcd_de@%0d", n), 32'(lcd_bus.lcd_de), 32'(exp_de));
      check_output($sformatf("lcd_rgb@%0d", n), 32'(lcd_bus.lcd_rgb), 32'(exp_rgb));
      check_output($sformatf("xpos@%0d", n), 32'(lcd_bus.pixel_xpos), 32'(exp_x));
      check_output($sformatf("ypos@%0d", n), 32'(lcd_bus.pixel_ypos), 32'(exp_y));
      if (use_table) begin
        for (int i = 0; i < NVEC; i++) begin
          if (vecs[i].n == n) begin
            check_output($sformatf("vec%0d.rd_en", i), 32'(lcd_bus.rd_en), 32'(vecs[i].rd_en));
            check_output($sformatf("vec%0d.de", i), 32'(lcd_bus.lcd_de), 32'(vecs[i].de));
            check_output($sformatf("vec%0d.hs", i), 32'(lcd_bus.lcd_hs), 32'(vecs[i].hs));
            check_output($sformatf("vec%0d.vs", i), 32'(lcd_bus.lcd_vs), 32'(vecs[i].vs));
            check_output($sformatf("vec%0d.rd_load", i), 32'(lcd_bus.rd_load), 32'(vecs[i].load));
            check_output($sformatf("vec%0d.read_valid", i), 32'(lcd_bus.sdram_read_valid),
                         32'(vecs[i].srv));
            check_output($sformatf("vec%0d.xpos", i), 32'(lcd_bus.pixel_xpos), 32'(vecs[i].x));
            check_output($sformatf("vec%0d.ypos", i), 32'(lcd_bus.pixel_ypos), 32'(vecs[i].y));
          end
        end
      end
      if (n >= 2 && n <= 121 && lcd_bus.rd_en) rd_cnt++;
      if (n >= 3 && n <= 122) begin
        if (lcd_bus.lcd_de)   de_cnt++;
        if (!lcd_bus.lcd_hs)  hs_lo++;
        if (!lcd_bus.lcd_vs)  vs_lo++;
        if (lcd_bus.rd_load)  ld_cnt++;
      end
    end
    check_output("frame rd_en count", 32'(rd_cnt), 32'd32);
    check_output("frame lcd_de count", 32'(de_cnt), 32'd32);
    check_output("frame hs low count", 32'(hs_lo), 32'd16);
    check_output("frame vs low count", 32'(vs_lo), 32'd15);
    check_output("frame rd_load count", 32'(ld_cnt), 32'd15);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, " rd_en"}, 32'(lcd_bus.rd_en), 32'd0);
    check_output({tag, " lcd_de"}, 32'(lcd_bus.lcd_de), 32'd0);
    check_output({tag, " lcd_hs"}, 32'(lcd_bus.lcd_hs), 32'd1);
    check_output({tag, " lcd_vs"}, 32'(lcd_bus.lcd_vs), 32'd1);
    check_output({tag, " rd_load"}, 32'(lcd_bus.rd_load), 32'd0);
    check_output({tag, " read_valid"}, 32'(lcd_bus.sdram_read_valid), 32'd0);
    check_output({tag, " xpos"}, 32'(lcd_bus.pixel_xpos), 32'd0);
    check_output({tag, " ypos"}, 32'(lcd_bus.pixel_ypos), 32'd0);
    check_output({tag, " lcd_rgb"}, 32'(lcd_bus.lcd_rgb), 32'd0);
  endtask

  initial begin
    //          n    rd_en de    hs    vs    load  srv   x  y
    vecs[0]  = '{1,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
    vecs[1]  = '{2,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
    vecs[2]  = '{3,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[3]  = '{4,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[4]  = '{5,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[5]  = '{17,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[6]  = '{18,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0};
    vecs[7]  = '{52,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0};
    vecs[8]  = '{53,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0};
    vecs[9]  = '{59,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6, 0};
    vecs[10] = '{60,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7, 0};
    vecs[11] = '{61,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0};
    vecs[12] = '{69,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1};
    vecs[13] = '{105, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7, 3};
    vecs[14] = '{106, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 3};
    vecs[15] = '{122, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 3};
    vecs[16] = '{123, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 3};

`ifdef LCD_TEST_PATTERN_EN
    lcd_bus.pattern_sel = 1'b0;
`endif
    rst_n = 1'b0;
    apply_stimulus(1'b1);
    lcd_bus.rd_data = 16'hABCD;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    check_output("rd_h_pixel", 32'(lcd_bus.rd_h_pixel), 32'd8);

    @(negedge clk);
    rst_n = 1'b1;
    // ends in the cycle where h_cnt=7, v_cnt=4 of the third frame
    run_frames(309, 1'b1, 0);

    apply_stimulus(1'b0);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (i >= 2) check_output($sformatf("drop rd_en+%0d", i), 32'(lcd_bus.rd_en), 32'd0);
      if (i >= 3) begin
        check_output($sformatf("drop lcd_de+%0d", i), 32'(lcd_bus.lcd_de), 32'd0);
        check_output($sformatf("drop read_valid+%0d", i), 32'(lcd_bus.sdram_read_valid), 32'd0);
        check_output($sformatf("drop rd_load+%0d", i), 32'(lcd_bus.rd_load), 32'd0);
        check_output($sformatf("drop xpos+%0d", i), 32'(lcd_bus.pixel_xpos), 32'd0);
        check_output($sformatf("drop ypos+%0d", i), 32'(lcd_bus.pixel_ypos), 32'd1);
      end
    end

    apply_stimulus(1'b1);
    run_frames(175, 1'b0, 1);

    // asynchronous reset in the middle of an active pixel run
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async reset");
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("held reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_frames(125, 1'b1, 0);

`ifdef LCD_TEST_PATTERN_EN
    @(negedge clk);
    rst_n = 1'b0;
    lcd_bus.pattern_sel = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 125; n++) begin
      bit exp_de;
      @(posedge clk);
      #1;
      exp_de = (n >= 3) && in_window(n - 3);
      check_output($sformatf("pat rd_en@%0d", n), 32'(lcd_bus.rd_en), 32'd0);
      check_output($sformatf("pat lcd_de@%0d", n), 32'(lcd_bus.lcd_de), 32'(exp_de));
      check_output($sformatf("pat read_valid@%0d", n), 32'(lcd_bus.sdram_read_valid),
                   32'(n >= 3));
      if (exp_de)
        check_output($sformatf("pat rgb@%0d", n), 32'(lcd_bus.lcd_rgb),
                     32'(bar_colors[h_of(n - 3) - HA]));
      else
        check_output($sformatf("pat rgb@%0d", n), 32'(lcd_bus.lcd_rgb), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
